// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: M-extension funct3
// encodings, controller state enumeration and operand-signedness decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] fn);
    return fn[2];
  endfunction

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
  function automatic logic signed_a(input logic [2:0] fn);
    return (fn == OP_MULH) || (fn == OP_MULHSU) || (fn == OP_DIV) || (fn == OP_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] fn);
    return (fn == OP_MULH) || (fn == OP_DIV) || (fn == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step, both built around a single XLEN+1-bit adder/subtractor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] add_x;
  logic [XLEN:0] add_y;
  logic [XLEN:0] add_sum;

  // Multiply: {hi,lo} is accumulator:multiplier, shifted right each step.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in;
  // the top bit of the subtraction result is the borrow.
  always_comb begin
    if (is_div) begin
      add_x = {hi, lo[XLEN-1]};
      add_y = {1'b0, opb};
    end else begin
      add_x = {1'b0, hi};
      add_y = lo[0] ? {1'b0, opb} : '0;
    end

    add_sum = add_x + (is_div ? ~add_y : add_y) + {{XLEN{1'b0}}, is_div};

    if (is_div) begin
      if (add_sum[XLEN]) begin
        hi_next = add_x[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_next = add_sum[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_next = add_sum[XLEN:1];
      lo_next = {add_sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed XLEN+1 cycle latency, valid/ready
// handshakes on both sides and synchronous flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] hi_next, lo_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  assign sign_a = signed_a(op) & a[XLEN-1];
  assign sign_b = signed_b(op) & b[XLEN-1];
  assign mag_a  = sign_a ? (~a + XLEN'(1)) : a;
  assign mag_b  = sign_b ? (~b + XLEN'(1)) : b;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div  (is_div_op(op_q)),
    .hi      (hi_q),
    .lo      (lo_q),
    .opb     (opb_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Sign correction of the unsigned magnitude result, then special-case override
  always_comb begin
    prod_fix = neg_q ? (~{hi_q, lo_q} + (2*XLEN)'(1)) : {hi_q, lo_q};
    quot_fix = neg_q ? (~lo_q + XLEN'(1)) : lo_q;
    rem_fix  = rneg_q ? (~hi_q + XLEN'(1)) : hi_q;
    case (op_q)
      OP_MUL:                      fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        if (dz_q)       fix_result = '1;
        else if (ovf_q) fix_result = a_q;
        else            fix_result = quot_fix;
      default:
        if (dz_q)       fix_result = a_q;
        else if (ovf_q) fix_result = '0;
        else            fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    a_d      = a_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_CALC;
            cnt_d   = CW'(XLEN);
            op_d    = op;
            tag_d   = tag_in;
            hi_d    = '0;
            lo_d    = mag_a;
            opb_d   = mag_b;
            a_d     = a;
            neg_d   = sign_a ^ sign_b;
            rneg_d  = sign_a;
            dz_d    = is_div_op(op) && (b == '0);
            ovf_d   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
          end
        end
        ST_CALC: begin
          hi_d  = hi_next;
          lo_d  = lo_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = fix_result;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      tag_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      a_q         <= a_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against
// a plain-arithmetic reference, plus stall, flush and mid-operation reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam int LAT  = XLEN + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [TAGW-1:0] tag_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  // Reference built from the architectural definition using 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sr;
    logic [63:0] ux, uy, ur;
    logic ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      OP_MUL:    begin ur = ux * uy; return ur[31:0]; end
      OP_MULH:   begin sr = sx * sy; return sr[63:32]; end
      OP_MULHSU: begin sr = sx * $signed(uy); return sr[63:32]; end
      OP_MULHU:  begin ur = ux * uy; return ur[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sr = sx / sy;
        return sr[31:0];
      end
      OP_DIVU: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      OP_REM: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        sr = sx % sy;
        return sr[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request at the falling edge; it must be taken at the next rising edge
  task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                input logic [TAGW-1:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    op       = f;
    a        = x;
    b        = y;
    tag_in   = t;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_output("accept", in_ready, 0);
  endtask

  task automatic wait_result(output logic [31:0] res, output logic [TAGW-1:0] tg, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    res = result;
    tg  = tag_out;
  endtask

  task automatic consume_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_output("consume_in_ready", in_ready, 1);
    check_output("consume_out_valid", out_valid, 0);
  endtask

  task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp, input logic [TAGW-1:0] t);
    logic [31:0] res;
    logic [TAGW-1:0] tg;
    int lat;
    apply_stimulus(f, x, y, t);
    wait_result(res, tg, lat);
    check_output({name, "_result"}, res, exp);
    check_output({name, "_latency"}, lat, LAT);
    check_output({name, "_tag"}, tg, t);
    consume_result();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] res, x, y, stall_res;
    logic [2:0] f;
    logic [TAGW-1:0] tg;
    int lat;
    bit seen;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{OP_DIVU,   32'h8000_0000,  32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{OP_REMU,   32'h8000_0007,  32'd0,         32'h8000_0007};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = OP_MUL; a = '0; b = '0; tag_in = '0;
    #12;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_result", result, 0);
    check_output("reset_tag_out", tag_out, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, TAGW'(i));

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      run_check($sformatf("rnd%0d_op%0d", i, f), f, x, y, ref_model(f, x, y), TAGW'($urandom));
    end

    // Consumer stall with a competing request held on in_valid
    apply_stimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h13);
    wait_result(stall_res, tg, lat);
    check_output("stall_result", stall_res, 32'hFFFF_FFFE);
    check_output("stall_latency", lat, LAT);
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3; tag_in = 5'h04;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("stall_out_valid", out_valid, 1);
      check_output("stall_in_ready", in_ready, 0);
      check_output("stall_hold_result", result, 32'hFFFF_FFFE);
      check_output("stall_tag_out", tag_out, 5'h13);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    check_output("stall_release_idle", in_ready, 1);
    check_output("stall_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1 check_output("stall_no_accept_in_done", in_ready, 1);

    // Flush in the fifth CALC cycle
    apply_stimulus(OP_MUL, 32'd12345, 32'd678, 5'h07);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_output("flush_idle", in_ready, 1);
    check_output("flush_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check_output("flush_never_valid", seen, 0);
    run_check("after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 5'h09);

    // Asynchronous reset while CALC is in progress
    apply_stimulus(OP_DIV, 32'd1000, 32'd3, 5'h1F);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("areset_in_ready", in_ready, 1);
    check_output("areset_out_valid", out_valid, 0);
    check_output("areset_result", result, 0);
    check_output("areset_tag_out", tag_out, 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; op = OP_REM; a = 32'hFFFF_FFF9; b = 32'd2; tag_in = 5'h0A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_output("areset_first_accept", in_ready, 0);
    wait_result(res, tg, lat);
    check_output("areset_next_result", res, 32'hFFFF_FFFF);
    check_output("areset_next_latency", lat, LAT);
    check_output("areset_next_tag", tg, 5'h0A);
    consume_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width (even, >= 8).
REQ-002 SHALL have parameter TAGW, default 5: width of the destination-register tag carried with each operation.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  operation request valid.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 a  input  XLEN  rs1 operand.
REQ-010 b  input  XLEN  rs2 operand.
REQ-011 tag_in  input  TAGW  destination tag.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  operation result.
REQ-015 tag_out  output  TAGW  tag of the current result.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-017 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-018 Accept SHALL occur on an edge with in_valid&&in_ready: latch op, tag, operand magnitudes and sign flags; load iteration counter with XLEN; go CALC.
REQ-019 CALC SHALL perform one iteration per cycle (shift-add multiply or restoring divide), decrementing the counter; on the edge where counter reaches 0, go FIX.
REQ-020 FIX SHALL apply sign correction and special-case override, register result, and go DONE.
REQ-021 Latency SHALL be fixed at XLEN+1 edges from the accept edge to out_valid rising, for every op and operand value.
REQ-022 DONE SHALL hold result and tag_out stable until out_valid&&out_ready; on that edge go IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle a result is consumed (in_ready low in DONE).
REQ-024 MUL SHALL return the low XLEN bits of the product; MULH/MULHSU/MULHU SHALL return the high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned interpretation respectively.
REQ-025 DIV/DIVU SHALL return the quotient truncated toward zero; REM/REMU SHALL return the remainder, with sign equal to the dividend's.
REQ-026 Divide by zero SHALL yield quotient all-ones and remainder = a, for signed and unsigned.
REQ-027 Signed overflow (a = most negative, b = -1) SHALL yield quotient = a and remainder 0.
REQ-028 Special cases SHALL be detected at accept and SHALL NOT change latency.
REQ-029 flush SHALL return FSM to IDLE on the next edge from any state, overriding accept and result handshake; a discarded result SHALL never show out_valid.
REQ-030 in_valid while in_ready is low SHALL be ignored with no state change.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, result 0, tag_out 0, out_valid 0, in_ready 1, immediately and independent of clk.
REQ-032 Reset mid-operation SHALL discard the operation; first accept is possible on the first edge after reset deassertion.

Structure
REQ-033 A shared package SHALL hold the op encodings (funct3 constants) and the FSM state enumeration; the ALU and control decode use the same package.
REQ-034 One sub-module, muldiv_step, SHALL contain the single-iteration datapath (shared XLEN+1-bit adder/subtractor with shift); muldiv_unit holds FSM, counter, sign handling and registers.
REQ-035 Only one XLEN+1-bit adder SHALL be used for both multiply and divide iterations.

Verification (XLEN=32)
REQ-036 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 edges after accept.
REQ-037 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-038 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-039 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; latency still 33.
REQ-040 out_ready held low 10 cycles in DONE with tag_in=0x13 -> result, tag_out=0x13, out_valid stable, in_ready low; release -> IDLE next edge; in_valid asserted during stall ignored.
REQ-041 flush on 5th CALC cycle -> IDLE next edge, out_valid never asserted, next op accepted and correct; async reset asserted in CALC -> outputs at reset values before next clock edge.
